wave_sample_streamer: RTL and testbench

WAVE_SAMPLE_STREAMER -- requirements
Module: wave_sample_streamer

---
 rtl/wave_sample_streamer.sv | 90 +++++++++
 tb/tb_wave_sample_streamer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wave_sample_streamer.sv
// wave_sample_streamer: captures sample_in every SAMPLE_DIV clocks into a FIFO and streams it to a UART.
// Define FRAME_HDR_EN to prefix every FRAME_LEN data bytes with HDR_BYTE.
module wave_sample_streamer #(
   parameter int SAMPLE_DIV = 10_000,
   parameter int FIFO_DEPTH = 16,
   parameter int FRAME_LEN = 8,
   parameter logic [7:0] HDR_BYTE = 8'hA5
) (
   input logic clk,
   input logic rst,
   input logic [7:0] sample_in,
   input logic uart_ready,
   output logic [7:0] uart_data,
   output logic uart_start,
   output logic overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int CW = $clog2(SAMPLE_DIV);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
   state_t state, next;
   logic [CW-1:0] tick_cnt;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [7:0] mem [FIFO_DEPTH];
   logic tick, full, empty, push, pop, load, send_hdr;
   assign tick = tick_cnt == CW'(SAMPLE_DIV - 1);
   assign empty = fifo_level == '0;
   assign full = fifo_level == (AW+1)'(FIFO_DEPTH);
   assign pop = load && !send_hdr;
   // a pop on the capture cycle frees the slot, so a full FIFO still accepts the sample
   assign push = tick && (!full || pop);
   assign uart_start = state == START;
   always_ff @(posedge clk or posedge rst)
      if (rst) tick_cnt <= '0;
      else tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fifo_level <= '0;
         overflow <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
         overflow <= overflow | (tick & full & ~pop);
      end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= sample_in;
`ifdef FRAME_HDR_EN
   logic hdr_pend;
   logic [7:0] frame_cnt;
   assign send_hdr = hdr_pend;
   // the frame closes on the pop of its last data byte; the FSM is busy until after that byte's START
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         hdr_pend <= 1'b1;
         frame_cnt <= '0;
      end else if (load) begin
         if (hdr_pend) hdr_pend <= 1'b0;
         else if (frame_cnt == 8'(FRAME_LEN - 1)) begin
            frame_cnt <= '0;
            hdr_pend <= 1'b1;
         end else frame_cnt <= frame_cnt + 1'b1;
      end
`else
   logic unused_frame_len;
   assign send_hdr = 1'b0;
   assign unused_frame_len = ^8'(FRAME_LEN);
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      load = 1'b0;
      case (state)
         IDLE: if (uart_ready && (!empty || send_hdr)) begin
            next = START;
            load = 1'b1;
         end
         START: next = WAIT_BUSY;
         WAIT_BUSY: if (!uart_ready) next = WAIT_DONE;
         default: if (uart_ready) next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) uart_data <= 8'h00;
      else if (load) uart_data <= send_hdr ? HDR_BYTE : mem[rd_ptr];
endmodule

// File: tb/tb_wave_sample_streamer.sv
// tb_wave_sample_streamer: directed scenarios with an expected-byte queue checked by an independent UART monitor.
// Works with and without FRAME_HDR_EN (header bytes are queued by frame position).
module tb_wave_sample_streamer;
   localparam int LEN = 3;
   localparam int LOW = 0, AUTO = 1, HIGH = 2;
`ifdef FRAME_HDR_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] sample_in = 8'h00;
   logic uart_ready;
   logic [7:0] uart_data;
   logic uart_start, overflow;
   logic [2:0] fifo_level;
   int total = 0, bad = 0, rx = 0, base = 0, dcount = 0, mode = LOW;
   int cyc = 0, last = -1, busy = 0;
   logic [7:0] exp_q[$];
   logic [7:0] e;

   wave_sample_streamer #(.SAMPLE_DIV(4), .FIFO_DEPTH(4), .FRAME_LEN(LEN), .HDR_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .sample_in(sample_in), .uart_ready(uart_ready),
      .uart_data(uart_data), .uart_start(uart_start), .overflow(overflow), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic push_data(input logic [7:0] v);
      exp_q.push_back(v);
      dcount++;
      if (HDR && dcount % LEN == 0) exp_q.push_back(8'hA5);
   endtask

   task automatic rst_on();
      rst = 1'b1;
      exp_q.delete();
      dcount = 0;
   endtask

   task automatic rst_off();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      if (HDR) exp_q.push_back(8'hA5);
      base = rx;
   endtask

   task automatic cap(input logic [7:0] v, input bit keep);
      sample_in = v;
      if (keep) push_data(v);
      repeat (4) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_rx(input int n);
      for (int i = 0; i < 200 && rx - base < n; i++) @(posedge clk);
      chk("rx_count", rx - base, n);
      @(negedge clk);
   endtask

   // UART model: LOW holds busy, HIGH never drops ready, AUTO drops ready for 3 cycles after each start
   initial begin
      uart_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (busy > 0) busy--;
         if (mode == AUTO && uart_start) busy = 3;
         uart_ready = (mode == HIGH) || (mode == AUTO && busy == 0);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rst) last = -1;
         else if (uart_start) begin
            if (last >= 0) chk("start_spacing", int'(cyc - last >= 4), 1);
            last = cyc;
            rx++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_byte actual=%02h required=none", uart_data);
            end else begin
               e = exp_q.pop_front();
               chk("uart_byte", uart_data, e);
            end
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_start", uart_start, 0);
      chk("rst_data", uart_data, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_level", fifo_level, 0);
      mode = AUTO;
      rst_off();
      for (int i = 0; i < 6; i++) cap(8'h01, 1'b1);
      chk("s1_rx", rx - base, HDR ? 5 : 4);
      chk("s1_ovf", overflow, 0);
      rst_on();
      mode = LOW;
      rst_off();
      for (int i = 1; i <= 4; i++) cap(8'(i), 1'b1);
      chk("s2_full_level", fifo_level, 4);
      chk("s2_no_ovf", overflow, 0);
      cap(8'h05, 1'b0);
      chk("s2_ovf", overflow, 1);
      chk("s2_level_kept", fifo_level, 4);
      sample_in = 8'hEE;
      repeat (8) push_data(8'hEE);
      @(posedge clk);
      #2 mode = AUTO;
      wait_rx(HDR ? 6 : 4);
      rst_on();
      #1;
      chk("s2_rst_ovf", overflow, 0);
      chk("s2_rst_level", fifo_level, 0);
      chk("s2_rst_start", uart_start, 0);
      mode = HDR ? HIGH : LOW;
      rst_off();
      cap(8'h11, 1'b1);
      cap(8'h22, 1'b1);
      chk("s3_level_pre", fifo_level, 2);
      sample_in = 8'h33;
      push_data(8'h33);
      @(posedge clk);
      #2 mode = LOW;
      @(posedge clk);
      #2 mode = HDR ? AUTO : LOW;
      @(posedge clk);
      #2 mode = AUTO;
      @(posedge clk);
      @(negedge clk);
      chk("s3_level_pushpop", fifo_level, 2);
      chk("s3_oldest", uart_data, 8'h11);
      repeat (4) push_data(8'h33);
      repeat (20) @(negedge clk);
      rst_on();
      mode = AUTO;
      rst_off();
      for (int i = 1; i <= 6; i++) cap(8'(i), 1'b1);
      chk("s4_ovf", overflow, 0);
      sample_in = 8'h77;
      repeat (4) push_data(8'h77);
      wait_rx(HDR ? 8 : 6);
      rst_on();
      mode = LOW;
      rst_off();
      for (int i = 0; i < (HDR ? 2 : 3); i++) cap(8'(8'h31 + i), 1'b1);
      @(posedge clk);
      #2 mode = AUTO;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("s5_level_pre", fifo_level, 3);
      rst_on();
      #1;
      chk("s5_rst_start", uart_start, 0);
      chk("s5_rst_level", fifo_level, 0);
      chk("s5_rst_ovf", overflow, 0);
      chk("s5_rst_data", uart_data, 0);
      rst_off();
      sample_in = 8'h5A;
      repeat (3) push_data(8'h5A);
      wait_rx(HDR ? 2 : 1);
      rst_on();
      mode = HIGH;
      rst_off();
      for (int i = 0; i < 4; i++) cap(8'(8'h61 + i), 1'b1);
      chk("s6_rx", rx - base, 1);
      chk("s6_level", fifo_level, HDR ? 4 : 3);
      chk("s6_ovf", overflow, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
